uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of `uart_rx`. It captures each byte `uart_rx` flags with its one-cycle `rcv` strobe and holds the bytes in a first-word-fall-through FIFO. It presents them to the consumer (echo logic, command parser, LED driver) over a valid/ready handshake. Overflow is reported with a sticky flag, so back-to-back characters at 115200 baud are not lost while the consumer is busy.

---
 rtl/uart_rx_fifo.sv | 48 ++++
 tb/tb_uart_rx_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind uart_rx.
// It has a valid/ready read side and a sticky overrun flag for dropped bytes.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rcv,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   output logic                  valid,
   input  logic                  ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overrun,
   input  logic                  clr_ovr
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp, rp;
   logic                  pop, push, drop;
   assign empty = count == '0;
   // count never exceeds DEPTH, so its top bit alone marks full
   assign full  = count[DEPTH_LOG2];
   assign valid = !empty;
   assign dout  = valid ? mem[rp] : 8'h00;
   assign pop   = valid && ready;
   assign push  = rcv && (!full || pop);
   assign drop  = rcv && full && !pop;
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count   <= (push && !pop) ? count + ONE : (pop && !push) ? count - ONE : count;
         overrun <= drop ? 1'b1 : clr_ovr ? 1'b0 : overrun;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven bench for uart_rx_fifo (depth 16).
module tb_uart_rx_fifo;
   logic       clk = 0, rst, rcv, ready, clr_ovr;
   logic [7:0] din, dout;
   logic       valid, empty, full, overrun;
   logic [4:0] count;
   int         errors = 0, checks = 0;

   typedef struct {
      int         pre;
      logic       rcv;
      logic [7:0] din;
      logic       ready, clr;
      logic       ev;
      logic [7:0] ed;
      int         ec;
   } vec_t;
   vec_t v[8];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .rcv(rcv), .din(din), .dout(dout), .valid(valid),
      .ready(ready), .count(count), .empty(empty), .full(full),
      .overrun(overrun), .clr_ovr(clr_ovr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] d, input logic rd, input logic c);
      rcv = r; din = d; ready = rd; clr_ovr = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1;
      drive(0, 8'h00, 0, 0);
      #1;
      // reset held for 3 cycles with rcv toggling: nothing may be stored
      for (int i = 0; i < 3; i++) begin
         drive(~rcv, 8'hE0 + 8'(i), 1, 0);
         tick();
         chk("rst_valid", valid, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_count", count, 0);
         chk("rst_ovr", overrun, 0);
         chk("rst_dout", dout, 8'h00);
      end
      rst = 0;
      drive(0, 8'h00, 0, 0);

      v[0] = '{0,  1, 8'h55, 0, 0, 1, 8'h55, 1};
      v[1] = '{39, 1, 8'h4B, 0, 0, 1, 8'h55, 2};
      v[2] = '{0,  0, 8'h00, 1, 0, 1, 8'h4B, 1};
      v[3] = '{0,  0, 8'h00, 1, 0, 0, 8'h00, 0};
      v[4] = '{0,  0, 8'h00, 1, 0, 0, 8'h00, 0};
      v[5] = '{0,  1, 8'h77, 1, 0, 1, 8'h77, 1};
      v[6] = '{0,  0, 8'h00, 1, 0, 0, 8'h00, 0};
      v[7] = '{0,  0, 8'h00, 0, 1, 0, 8'h00, 0};
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < v[i].pre; k++) begin
            drive(0, 8'h00, 0, 0);
            tick();
         end
         drive(v[i].rcv, v[i].din, v[i].ready, v[i].clr);
         tick();
         chk($sformatf("vec%0d_valid", i), valid, v[i].ev);
         chk($sformatf("vec%0d_dout", i), dout, v[i].ed);
         chk($sformatf("vec%0d_count", i), count, v[i].ec);
         chk($sformatf("vec%0d_ovr", i), overrun, 0);
      end

      // fill to 16, then one byte too many
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(i), 0, 0);
         tick();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      chk("fill_ovr", overrun, 0);
      drive(1, 8'h10, 0, 0);
      tick();
      chk("ovf_full", full, 1);
      chk("ovf_count", count, 16);
      chk("ovf_ovr", overrun, 1);
      chk("ovf_head", dout, 8'h00);
      drive(0, 8'h00, 0, 1);
      tick();
      chk("clr_ovr", overrun, 0);
      drive(1, 8'h11, 0, 1);
      tick();
      chk("drop_clr_set_wins", overrun, 1);
      chk("drop_clr_count", count, 16);
      drive(0, 8'h00, 0, 1);
      tick();
      chk("clr_ovr2", overrun, 0);

      // push and pop together while full
      chk("sim_head", dout, 8'h00);
      drive(1, 8'hAA, 1, 0);
      tick();
      chk("sim_count", count, 16);
      chk("sim_ovr", overrun, 0);
      chk("sim_full", full, 1);
      for (int i = 1; i <= 16; i++) begin
         drive(0, 8'h00, 1, 0);
         chk($sformatf("drain%0d", i), dout, (i == 16) ? 8'hAA : 8'(i));
         tick();
         chk($sformatf("drain%0d_count", i), count, 16 - i);
      end
      chk("drain_valid", valid, 0);
      chk("drain_dout", dout, 8'h00);

      // one push and one pop per cycle: pointers wrap twice
      for (int i = 0; i < 40; i++) begin
         drive(1, 8'h20 + 8'(i), 1, 0);
         tick();
         chk($sformatf("wrap%0d_dout", i), dout, 8'h20 + 8'(i));
         chk($sformatf("wrap%0d_count", i), count, 1);
      end
      drive(0, 8'h00, 1, 0);
      tick();
      chk("wrap_end_valid", valid, 0);

      // reset mid-burst
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'hC0 + 8'(i), 0, 0);
         tick();
      end
      chk("pre_rst_count", count, 5);
      drive(0, 8'h00, 0, 0);
      rst = 1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_valid", valid, 0);
      tick();
      rst = 0;
      drive(1, 8'h31, 0, 0);
      tick();
      chk("post_rst_count", count, 1);
      chk("post_rst_dout", dout, 8'h31);
      drive(0, 8'h00, 1, 0);
      tick();
      chk("post_rst_empty", empty, 1);
      chk("post_rst_dout0", dout, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
